// File: rtl/mmu_pkg.sv
// Shared MMU types and constants: PTE layout, walker state encoding, Sv39 geometry.
package mmu_pkg;

  localparam int PTW_LEVELS    = 3;
  localparam int PAGE_OFFSET_W = 12;
  localparam int PTE_IDX_W     = 9;
  localparam int PTE_PPN_W     = 20;

  localparam int PTE_V        = 0;
  localparam int PTE_R        = 1;
  localparam int PTE_W        = 2;
  localparam int PTE_X        = 3;
  localparam int PTE_U        = 4;
  localparam int PTE_G        = 5;
  localparam int PTE_A        = 6;
  localparam int PTE_D        = 7;
  localparam int PTE_PPN_LSB  = 10;
  localparam int PTE_PPN_MSB  = 29;
  localparam int PTE_HPPN_LSB = 30;
  localparam int PTE_HPPN_MSB = 53;
  localparam int PTE_RSVD_LSB = 54;
  localparam int PTE_RSVD_MSB = 63;

  // Low 30 bits of a raw PTE map directly onto this layout.
  typedef struct packed {
    logic [PTE_PPN_W-1:0] ppn;
    logic [1:0]           rsw;
    logic                 d;
    logic                 a;
    logic                 g;
    logic                 u;
    logic                 x;
    logic                 w;
    logic                 r;
    logic                 v;
  } pte_t;

  typedef enum logic [2:0] {
    PTW_IDLE,
    PTW_REQ,
    PTW_WAIT,
    PTW_RESP,
    PTW_DRAIN
  } ptw_state_t;

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational PTE classifier: pointer to next level, valid leaf, or page fault.
module ptw_pte_check
  import mmu_pkg::*;
(
  input  logic [63:0]          pte_raw,
  input  logic [1:0]           level,
  input  logic                 store,
  output logic                 is_leaf,
  output logic                 is_pointer,
  output logic                 is_error,
  output logic [PTE_PPN_W-1:0] ppn
);

  pte_t f;
  logic malformed;
  logic no_perm;
  logic misaligned;
  logic leaf_fault;
  logic unused_bits;

  assign f           = pte_t'(pte_raw[PTE_PPN_MSB:0]);
  assign ppn         = f.ppn;
  assign unused_bits = ^{f.rsw, f.g, f.u};

  // High PPN and reserved bits must be zero since physical space is only 32 bits.
  assign malformed = !f.v || (!f.r && f.w) ||
                     (pte_raw[PTE_RSVD_MSB:PTE_HPPN_LSB] != '0);
  assign no_perm   = !f.r && !f.x;

  always_comb begin
    misaligned = 1'b0;
    case (level)
      2'd2:    misaligned = (f.ppn[2*PTE_IDX_W-1:0] != '0);
      2'd1:    misaligned = (f.ppn[PTE_IDX_W-1:0] != '0);
      default: misaligned = 1'b0;
    endcase
  end

  // No hardware A/D update: a clear A, or a store to a clean page, faults.
  assign leaf_fault = !f.a || (store && !f.d) || misaligned;

  assign is_pointer = !malformed && no_perm && (level != 2'd0);
  assign is_leaf    = !malformed && !no_perm && !leaf_fault;
  assign is_error   = !is_pointer && !is_leaf;

endmodule

// File: rtl/ptw_walker.sv
// Sv39-style page-table walker: one walk, one outstanding PTE read at a time.
//   state | meaning
//   IDLE  | waiting for a TLB miss
//   REQ   | PTE read request presented to memory
//   WAIT  | read accepted, waiting for PTE data
//   RESP  | one-cycle result pulse to the TLB
//   DRAIN | walk aborted, swallowing the outstanding read
module ptw_walker
  import mmu_pkg::*;
#(
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 20,
  parameter int PADDR_W = 32,
  parameter int DATA_W  = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [VPN_W-1:0]   req_vpn_i,
  input  logic               req_store_i,
  input  logic [PPN_W-1:0]   satp_ppn_i,
  input  logic               invalidate_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [PADDR_W-1:0] mem_req_addr_o,
  input  logic               mem_resp_valid_i,
  input  logic [DATA_W-1:0]  mem_resp_data_i,
  output logic               resp_valid_o,
  output logic               resp_error_o,
  output logic [PPN_W+9:0]   resp_pte_o,
  output logic [1:0]         resp_level_o,
  output logic               pmu_walk_o,
  output logic               pmu_mem_access_o
);

  ptw_state_t state, state_nxt;

  logic [VPN_W-1:0]     vpn;
  logic                 store;
  logic [PPN_W-1:0]     cur_ppn;
  logic [1:0]           level;
  pte_t                 res_pte;
  logic                 res_err;

  logic                 accept;
  logic                 issue;
  logic                 take_ptr;
  logic                 take_result;
  logic                 chk_leaf;
  logic                 chk_ptr;
  logic                 chk_err;
  logic [PTE_PPN_W-1:0] chk_ppn;
  logic [PTE_IDX_W-1:0] idx;

  ptw_pte_check u_check (
    .pte_raw    (mem_resp_data_i),
    .level      (level),
    .store      (store),
    .is_leaf    (chk_leaf),
    .is_pointer (chk_ptr),
    .is_error   (chk_err),
    .ppn        (chk_ppn)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= PTW_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    issue           = 1'b0;
    take_ptr        = 1'b0;
    take_result     = 1'b0;
    req_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    resp_valid_o    = 1'b0;
    case (state)
      PTW_IDLE: begin
        req_ready_o = !invalidate_i && !rst_i;
        accept      = req_valid_i && req_ready_o;
        if (accept) state_nxt = PTW_REQ;
      end
      PTW_REQ: begin
        // Abort before the handshake so no read is ever left dangling.
        if (invalidate_i) begin
          state_nxt = PTW_IDLE;
        end else begin
          mem_req_valid_o = 1'b1;
          if (mem_req_ready_i) begin
            issue     = 1'b1;
            state_nxt = PTW_WAIT;
          end
        end
      end
      PTW_WAIT: begin
        if (invalidate_i) begin
          state_nxt = mem_resp_valid_i ? PTW_IDLE : PTW_DRAIN;
        end else if (mem_resp_valid_i) begin
          if (chk_ptr) begin
            take_ptr  = 1'b1;
            state_nxt = PTW_REQ;
          end else begin
            take_result = 1'b1;
            state_nxt   = PTW_RESP;
          end
        end
      end
      PTW_RESP: begin
        resp_valid_o = 1'b1;
        state_nxt    = PTW_IDLE;
      end
      PTW_DRAIN: begin
        if (mem_resp_valid_i) state_nxt = PTW_IDLE;
      end
      default: state_nxt = PTW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vpn     <= '0;
      store   <= 1'b0;
      cur_ppn <= '0;
      level   <= 2'd0;
      res_pte <= '0;
      res_err <= 1'b0;
    end else begin
      if (accept) begin
        vpn     <= req_vpn_i;
        store   <= req_store_i;
        cur_ppn <= satp_ppn_i;
        level   <= 2'd2;
      end
      if (take_ptr) begin
        cur_ppn <= chk_ppn;
        level   <= level - 2'd1;
      end
      if (take_result) begin
        res_err <= chk_err;
        res_pte <= chk_leaf ? pte_t'(mem_resp_data_i[PTE_PPN_MSB:0]) : '0;
      end
    end
  end

  always_comb begin
    case (level)
      2'd2:    idx = vpn[3*PTE_IDX_W-1:2*PTE_IDX_W];
      2'd1:    idx = vpn[2*PTE_IDX_W-1:PTE_IDX_W];
      default: idx = vpn[PTE_IDX_W-1:0];
    endcase
  end

  assign mem_req_addr_o   = (state == PTW_REQ) ? {cur_ppn, idx, 3'b000} : '0;
  assign pmu_walk_o       = accept;
  assign pmu_mem_access_o = issue;
  assign resp_error_o     = resp_valid_o && res_err;
  assign resp_pte_o       = resp_valid_o ? res_pte : '0;
  assign resp_level_o     = resp_valid_o ? level : 2'd0;

endmodule
